mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-port data memory between two requesters: instruction fetch (port F) and load/store (port D).
- Sits between the core's fetch and memory stages and the memory instance.
- Sequences every access as an arbitrate / access / respond cycle.
- Fixed priority to D, with a starvation guard that forces an F grant after a bounded run of D grants.

Parameters:
- DATA_SIZE, 32, word width of data on every port.
- ADDRESS_SIZE, 32, address width on every port.
- STARVE_LIMIT, 3, max consecutive D grants while F is pending before F is forced (1..15).

Ports:
- CLK  input  1  system clock, all state on rising edge.
- RST  input  1  asynchronous, active-high reset.
- F_REQ  input  1  fetch request, held until F_ACK.
- F_ADDRESS  input  ADDRESS_SIZE  fetch address, stable while F_REQ is high.
- F_ACK  output  1  one-cycle pulse, fetch complete.
- F_DATA  output  DATA_SIZE  fetch read data, valid while F_ACK is high.
- D_REQ  input  1  load/store request, held until D_ACK.
- D_WRITE  input  1  1 = store, 0 = load; stable while D_REQ is high.
- D_ADDRESS  input  ADDRESS_SIZE  load/store address.
- D_IN_DATA  input  DATA_SIZE  store data.
- D_ACK  output  1  one-cycle pulse, load/store complete.
- D_OUT_DATA  output  DATA_SIZE  load data, valid while D_ACK is high.
- MEM_ADDRESS  output  ADDRESS_SIZE  to memory address.
- MEM_WRITE  output  1  to memory write strobe.
- MEM_IN_DATA  output  DATA_SIZE  to memory write data.
- MEM_OUT_DATA  input  DATA_SIZE  from memory; registered read, valid the cycle after the address is presented.

Behaviour:
- FSM states: IDLE, ACCESS, RESP.
- Reset state: IDLE; owner = none; starve count = 0; all outputs 0.
- IDLE:
  - No request: stay in IDLE.
  - Otherwise pick a winner, latch winner id, address, write flag and write data into internal registers, go to ACCESS.
- Winner selection in IDLE:
  - Only one REQ high: that port wins.
  - Both high and starve count < STARVE_LIMIT: D wins, starve count increments.
  - Both high and starve count = STARVE_LIMIT: F wins, starve count clears.
  - F wins for any reason: starve count clears.
  - D wins with F idle: starve count clears.
- ACCESS (1 cycle):
  - MEM_ADDRESS = latched address.
  - MEM_WRITE = latched write flag; always 0 for F.
  - MEM_IN_DATA = latched data.
  - Next state RESP.
- RESP (1 cycle):
  - MEM_WRITE = 0.
  - Winner's ACK = 1.
  - Read: winner's data output = MEM_OUT_DATA.
  - Next state IDLE.
- Latency: REQ sampled in IDLE at edge N; ACK high in cycle N+2. Throughput is one access per 3 cycles.
- Requester handshake:
  - Must drop REQ or present a new request on the cycle after ACK.
  - A REQ still high in the IDLE cycle after ACK is treated as a new request.
- Data outputs: F_DATA and D_OUT_DATA hold their last value outside ACK; only the ACK cycle is meaningful.
- ACK: never high on both ports in the same cycle; at most one pulse per granted transaction.
- REQ dropped mid-transaction: the latched transaction still completes and ACK is pulsed anyway. No abort.
- Input changes after grant: address and data changes have no effect because they were latched in IDLE.
- MEM_WRITE: high for exactly one cycle per store, only in ACCESS.
- RST asserted in any state:
  - Immediate return to IDLE; outputs and counters cleared.
  - An in-flight transaction is dropped with no ACK; the requester reissues.
  - A write in ACCESS is aborted by MEM_WRITE dropping asynchronously.

Test Plan:
- Reset then idle: RST=1 for 2 cycles, release, no REQ for 5 cycles -> all outputs 0, MEM_WRITE never high.
- Single store then load:
  - D_REQ, D_WRITE=1, D_ADDRESS=0x4, D_IN_DATA=0xDEADBEEF -> MEM_WRITE=1 for one cycle with MEM_ADDRESS=0x4, D_ACK at +2.
  - Load of 0x4 -> D_ACK at +2 with D_OUT_DATA=0xDEADBEEF.
- Simultaneous requests:
  - F_REQ(0x10) and D_REQ load(0x20) raised together -> D acked first at cycle 2, F acked at cycle 5.
  - F_DATA equals the memory word at 0x10.
- Starvation guard, STARVE_LIMIT=3:
  - F_REQ held, D_REQ reissued every transaction -> grant order D,D,D,F,D,D,D,F.
  - F_ACK at cycles 11 and 23.
- Reset mid-access: assert RST while a D store is in ACCESS -> MEM_WRITE falls immediately, no D_ACK, FSM in IDLE after release.
- Early REQ drop: D_REQ deasserted in ACCESS -> D_ACK still pulses once in RESP; no second grant follows.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Two-port arbiter in front of a single-port memory with a registered read.
// Each access runs IDLE -> ACCESS -> RESP; D has priority, bounded by a starvation guard for F.
module mem_port_arbiter #(
    parameter int DATA_SIZE    = 32,
    parameter int ADDRESS_SIZE = 32,
    parameter int STARVE_LIMIT = 3
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    F_REQ,
    input  logic [ADDRESS_SIZE-1:0] F_ADDRESS,
    output logic                    F_ACK,
    output logic [DATA_SIZE-1:0]    F_DATA,
    input  logic                    D_REQ,
    input  logic                    D_WRITE,
    input  logic [ADDRESS_SIZE-1:0] D_ADDRESS,
    input  logic [DATA_SIZE-1:0]    D_IN_DATA,
    output logic                    D_ACK,
    output logic [DATA_SIZE-1:0]    D_OUT_DATA,
    output logic [ADDRESS_SIZE-1:0] MEM_ADDRESS,
    output logic                    MEM_WRITE,
    output logic [DATA_SIZE-1:0]    MEM_IN_DATA,
    input  logic [DATA_SIZE-1:0]    MEM_OUT_DATA
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_F, OWN_D} owner_t;

    state_t                  state, state_nx;
    owner_t                  owner, owner_nx;
    logic [3:0]              starve, starve_nx;
    logic [ADDRESS_SIZE-1:0] lat_addr, lat_addr_nx;
    logic                    lat_write, lat_write_nx;
    logic [DATA_SIZE-1:0]    lat_data, lat_data_nx;
    logic [DATA_SIZE-1:0]    f_data_q, d_data_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            owner     <= OWN_NONE;
            starve    <= '0;
            lat_addr  <= '0;
            lat_write <= 1'b0;
            lat_data  <= '0;
            f_data_q  <= '0;
            d_data_q  <= '0;
        end else begin
            state     <= state_nx;
            owner     <= owner_nx;
            starve    <= starve_nx;
            lat_addr  <= lat_addr_nx;
            lat_write <= lat_write_nx;
            lat_data  <= lat_data_nx;
            if (state == RESP && owner == OWN_F)
                f_data_q <= MEM_OUT_DATA;
            if (state == RESP && owner == OWN_D && !lat_write)
                d_data_q <= MEM_OUT_DATA;
        end
    end

    always_comb begin
        state_nx     = state;
        owner_nx     = owner;
        starve_nx    = starve;
        lat_addr_nx  = lat_addr;
        lat_write_nx = lat_write;
        lat_data_nx  = lat_data;
        MEM_ADDRESS  = '0;
        MEM_WRITE    = 1'b0;
        MEM_IN_DATA  = '0;
        F_ACK        = 1'b0;
        D_ACK        = 1'b0;
        F_DATA       = f_data_q;
        D_OUT_DATA   = d_data_q;

        case (state)
            IDLE: begin
                // D wins unless F has been passed over STARVE_LIMIT times in a row
                if (D_REQ && (!F_REQ || starve < 4'(STARVE_LIMIT))) begin
                    owner_nx     = OWN_D;
                    lat_addr_nx  = D_ADDRESS;
                    lat_write_nx = D_WRITE;
                    lat_data_nx  = D_IN_DATA;
                    starve_nx    = F_REQ ? starve + 4'd1 : '0;
                    state_nx     = ACCESS;
                end else if (F_REQ) begin
                    owner_nx     = OWN_F;
                    lat_addr_nx  = F_ADDRESS;
                    lat_write_nx = 1'b0;
                    lat_data_nx  = '0;
                    starve_nx    = '0;
                    state_nx     = ACCESS;
                end
            end
            ACCESS: begin
                MEM_ADDRESS = lat_addr;
                MEM_WRITE   = lat_write;
                MEM_IN_DATA = lat_data;
                state_nx    = RESP;
            end
            RESP: begin
                if (owner == OWN_F) begin
                    F_ACK  = 1'b1;
                    F_DATA = MEM_OUT_DATA;
                end else if (owner == OWN_D) begin
                    D_ACK = 1'b1;
                    if (!lat_write)
                        D_OUT_DATA = MEM_OUT_DATA;
                end
                owner_nx = OWN_NONE;
                state_nx = IDLE;
            end
            default: begin
                owner_nx = OWN_NONE;
                state_nx = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and randomized bench for mem_port_arbiter with a registered-read memory
// model and a transaction-level arbitration/memory reference model.
module tb_mem_port_arbiter;

    localparam int LIMIT = 3;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        F_REQ = 1'b0;
    logic [31:0] F_ADDRESS = '0;
    logic        F_ACK;
    logic [31:0] F_DATA;
    logic        D_REQ = 1'b0;
    logic        D_WRITE = 1'b0;
    logic [31:0] D_ADDRESS = '0;
    logic [31:0] D_IN_DATA = '0;
    logic        D_ACK;
    logic [31:0] D_OUT_DATA;
    logic [31:0] MEM_ADDRESS;
    logic        MEM_WRITE;
    logic [31:0] MEM_IN_DATA;
    logic [31:0] MEM_OUT_DATA = '0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    mem_port_arbiter #(.DATA_SIZE(32), .ADDRESS_SIZE(32), .STARVE_LIMIT(LIMIT)) dut (
        .CLK(CLK), .RST(RST),
        .F_REQ(F_REQ), .F_ADDRESS(F_ADDRESS), .F_ACK(F_ACK), .F_DATA(F_DATA),
        .D_REQ(D_REQ), .D_WRITE(D_WRITE), .D_ADDRESS(D_ADDRESS), .D_IN_DATA(D_IN_DATA),
        .D_ACK(D_ACK), .D_OUT_DATA(D_OUT_DATA),
        .MEM_ADDRESS(MEM_ADDRESS), .MEM_WRITE(MEM_WRITE), .MEM_IN_DATA(MEM_IN_DATA),
        .MEM_OUT_DATA(MEM_OUT_DATA)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    function automatic logic [31:0] init_pat(input int idx);
        return 32'h1357_0000 ^ (32'(idx) * 32'h9E37_79B9);
    endfunction

    // Memory model: 64 words, unwritten words read back as init_pat
    logic [31:0] mem [64];
    bit          mem_valid [64];
    logic        mem_ok;
    assign mem_ok = (MEM_ADDRESS[31:8] == '0) && (MEM_ADDRESS[1:0] == 2'b00);
    always @(posedge CLK) begin
        if (MEM_WRITE && mem_ok) begin
            mem[MEM_ADDRESS[7:2]]       <= MEM_IN_DATA;
            mem_valid[MEM_ADDRESS[7:2]] <= 1'b1;
        end
        MEM_OUT_DATA <= mem_valid[MEM_ADDRESS[7:2]] ? mem[MEM_ADDRESS[7:2]]
                                                    : init_pat(int'(MEM_ADDRESS[7:2]));
    end

    logic [31:0] ref_mem [64];
    int          starve;
    logic [31:0] last_f, last_d;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ctl"}, 32'({F_ACK, D_ACK, MEM_WRITE}), 32'd0);
        chk({tag, "_fdata"}, F_DATA, 32'd0);
        chk({tag, "_ddata"}, D_OUT_DATA, 32'd0);
        chk({tag, "_maddr"}, MEM_ADDRESS, 32'd0);
        chk({tag, "_mdin"}, MEM_IN_DATA, 32'd0);
    endtask

    function automatic logic [31:0] rnd_addr();
        return 32'($urandom_range(0, 63)) << 2;
    endfunction

    // Called at a negedge in IDLE; returns at the negedge of the following IDLE cycle.
    // who: 0 none, 1 F, 2 D; ack_cyc: cycle number of the ACK.
    task automatic do_txn(input bit drop_early, input bit scramble, output int who, output int ack_cyc);
        logic [31:0] eaddr, edata;
        bit          ewr;
        ack_cyc = -1;
        if (!F_REQ && !D_REQ) begin
            who = 0;
            @(negedge CLK);
            chk("idle_quiet", 32'({F_ACK, D_ACK, MEM_WRITE}), 32'd0);
            return;
        end
        if (F_REQ && D_REQ) begin
            if (starve < LIMIT) begin who = 2; starve++; end
            else begin who = 1; starve = 0; end
        end else if (F_REQ) begin
            who = 1; starve = 0;
        end else begin
            who = 2; starve = 0;
        end
        if (who == 1) begin eaddr = F_ADDRESS; ewr = 1'b0; edata = '0; end
        else begin eaddr = D_ADDRESS; ewr = D_WRITE; edata = D_IN_DATA; end

        @(negedge CLK);
        chk("acc_addr", MEM_ADDRESS, eaddr);
        chk("acc_wr", 32'(MEM_WRITE), 32'(ewr));
        if (ewr) chk("acc_wdata", MEM_IN_DATA, edata);
        chk("acc_noack", 32'({F_ACK, D_ACK}), 32'd0);
        if (scramble) begin
            F_ADDRESS = rnd_addr();
            D_ADDRESS = rnd_addr();
            D_IN_DATA = $urandom;
        end
        if (drop_early) begin
            if (who == 1) F_REQ = 1'b0; else D_REQ = 1'b0;
        end

        @(negedge CLK);
        ack_cyc = cyc;
        chk("resp_fack", 32'(F_ACK), 32'(who == 1));
        chk("resp_dack", 32'(D_ACK), 32'(who == 2));
        chk("resp_wr", 32'(MEM_WRITE), 32'd0);
        if (who == 1) begin
            chk("f_data", F_DATA, ref_mem[eaddr[7:2]]);
            last_f = ref_mem[eaddr[7:2]];
        end else if (!ewr) begin
            chk("d_data", D_OUT_DATA, ref_mem[eaddr[7:2]]);
            last_d = ref_mem[eaddr[7:2]];
        end
        if (ewr) ref_mem[eaddr[7:2]] = edata;
        if (who == 1) F_REQ = 1'b0; else D_REQ = 1'b0;

        @(negedge CLK);
        chk("idle_noack", 32'({F_ACK, D_ACK, MEM_WRITE}), 32'd0);
        chk("f_hold", F_DATA, last_f);
        chk("d_hold", D_OUT_DATA, last_d);
    endtask

    initial begin
        int who, ac, base, fack0, fack1, nf;
        int exp_order [8] = '{2, 2, 2, 1, 2, 2, 2, 1};

        for (int i = 0; i < 64; i++) ref_mem[i] = init_pat(i);
        starve = 0; last_f = '0; last_d = '0;

        // Reset, then idle
        repeat (2) @(negedge CLK);
        chk_all_zero("in_reset");
        RST = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            chk_all_zero("idle_after_reset");
        end

        // Store then load
        D_REQ = 1'b1; D_WRITE = 1'b1; D_ADDRESS = 32'h4; D_IN_DATA = 32'hDEAD_BEEF;
        do_txn(1'b0, 1'b0, who, ac);
        chk("store_who", 32'(who), 32'd2);
        D_REQ = 1'b1; D_WRITE = 1'b0; D_ADDRESS = 32'h4;
        do_txn(1'b0, 1'b0, who, ac);
        chk("load_back", D_OUT_DATA, 32'hDEAD_BEEF);

        // Simultaneous F and D
        base = cyc;
        F_REQ = 1'b1; F_ADDRESS = 32'h10;
        D_REQ = 1'b1; D_WRITE = 1'b0; D_ADDRESS = 32'h20;
        do_txn(1'b0, 1'b0, who, ac);
        chk("simul_first", 32'(who), 32'd2);
        chk("simul_dack_cyc", 32'(ac - base), 32'd2);
        do_txn(1'b0, 1'b0, who, ac);
        chk("simul_second", 32'(who), 32'd1);
        chk("simul_fack_cyc", 32'(ac - base), 32'd5);
        chk("simul_fdata", F_DATA, init_pat(4));

        // Starvation guard: F held, D reissued every transaction
        base = cyc; nf = 0; fack0 = -1; fack1 = -1;
        for (int i = 0; i < 8; i++) begin
            if (!F_REQ) begin F_REQ = 1'b1; F_ADDRESS = rnd_addr(); end
            if (!D_REQ) begin
                D_REQ = 1'b1; D_WRITE = 1'($urandom_range(0, 1));
                D_ADDRESS = rnd_addr(); D_IN_DATA = $urandom;
            end
            do_txn(1'b0, 1'b0, who, ac);
            chk("starve_order", 32'(who), 32'(exp_order[i]));
            if (who == 1) begin
                if (nf == 0) fack0 = ac - base; else fack1 = ac - base;
                nf++;
            end
        end
        chk("starve_fack_a", 32'(fack0), 32'd11);
        chk("starve_fack_b", 32'(fack1), 32'd23);
        do_txn(1'b0, 1'b0, who, ac);
        chk("starve_tail_d", 32'(who), 32'd2);

        // Reset during a store in ACCESS
        D_REQ = 1'b1; D_WRITE = 1'b1; D_ADDRESS = 32'h8; D_IN_DATA = 32'hCAFE_F00D;
        @(negedge CLK);
        chk("rst_pre_wr", 32'(MEM_WRITE), 32'd1);
        #2 RST = 1'b1;
        #1 chk("rst_async_wr", 32'(MEM_WRITE), 32'd0);
        chk("rst_async_addr", MEM_ADDRESS, 32'd0);
        D_REQ = 1'b0; D_WRITE = 1'b0;
        starve = 0; last_f = '0; last_d = '0;
        @(negedge CLK);
        chk_all_zero("rst_held");
        RST = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            chk_all_zero("rst_after");
        end
        D_REQ = 1'b1; D_WRITE = 1'b0; D_ADDRESS = 32'h8;
        do_txn(1'b0, 1'b0, who, ac);
        chk("rst_no_write", D_OUT_DATA, init_pat(2));

        // Early REQ drop in ACCESS
        D_REQ = 1'b1; D_WRITE = 1'b0; D_ADDRESS = 32'h4;
        do_txn(1'b1, 1'b0, who, ac);
        chk("early_who", 32'(who), 32'd2);
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            chk("early_no_regrant", 32'({F_ACK, D_ACK, MEM_WRITE}), 32'd0);
        end

        // Randomized traffic
        for (int i = 0; i < 60; i++) begin
            if (!F_REQ && $urandom_range(0, 1) == 1) begin
                F_REQ = 1'b1; F_ADDRESS = rnd_addr();
            end
            if (!D_REQ && $urandom_range(0, 3) != 0) begin
                D_REQ = 1'b1; D_WRITE = 1'($urandom_range(0, 1));
                D_ADDRESS = rnd_addr(); D_IN_DATA = $urandom;
            end
            do_txn(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), who, ac);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
